// File: rtl/multdiv_pkg.sv
// Shared definitions for the multiply/divide sequencer: FSM encoding,
// operation codes and default sizing.
package multdiv_pkg;

  localparam int TIMEOUT_DEFAULT = 40;
  localparam int RD_W_DEFAULT    = 5;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } md_state_e;

  // A ready seen in the first WAIT cycle may be left over from the previous divide
  function automatic logic rdy_honoured(input logic rdy, input logic first_wait);
    return rdy & ~first_wait;
  endfunction

endpackage

// File: rtl/multdiv_ctrl_if.sv
// Request and writeback handshake bundle between the pipeline and the
// mult/div sequencer.
interface multdiv_ctrl_if
  import multdiv_pkg::*;
#(
  parameter int RD_W = RD_W_DEFAULT
);

  logic            req_valid;
  logic            req_op;
  logic [31:0]     req_a;
  logic [31:0]     req_b;
  logic [RD_W-1:0] req_rd;
  logic            req_ready;

  logic            wb_valid;
  logic            wb_ready;
  logic [31:0]     wb_data;
  logic [RD_W-1:0] wb_rd;
  logic            wb_exception;

  modport master (
    output req_valid, req_op, req_a, req_b, req_rd,
    input  req_ready,
    input  wb_valid, wb_data, wb_rd, wb_exception,
    output wb_ready
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_rd,
    output req_ready,
    output wb_valid, wb_data, wb_rd, wb_exception,
    input  wb_ready
  );

endinterface

// File: rtl/md_timeout_counter.sv
// WAIT-state cycle counter; expired flags the last cycle allowed before
// the sequencer forces a timeout completion.
module md_timeout_counter
  import multdiv_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int CNT_W   = $clog2(TIMEOUT)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             expired
);

  logic [CNT_W-1:0] count_r;
  logic             expired_s;

  assign expired_s = (count_r == CNT_W'(TIMEOUT - 1));

  // Count register: clear wins, then increment, saturating at the limit
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (enable && !expired_s) begin
      count_r <= count_r + CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count   = count_r;
  assign expired = expired_s;

endmodule

// File: rtl/multdiv_ctrl.sv
// Sequencer between execute and the shared multiplier/divider: latches one
// request, pulses the unit, waits with timeout, hands the result to writeback.
module multdiv_ctrl
  import multdiv_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int RD_W    = RD_W_DEFAULT
) (
  input  logic            clock,
  input  logic            reset,
  multdiv_ctrl_if.slave   bus,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic [RD_W-1:0] busy_rd,
  output logic [31:0]     md_a,
  output logic [31:0]     md_b,
  output logic            md_ctrl_mult,
  output logic            md_ctrl_div,
  input  logic [31:0]     md_result,
  input  logic            md_exception,
  input  logic            md_resultRDY
);

  localparam int CNT_W = $clog2(TIMEOUT);

  md_state_e       state_r, state_nxt_s;
  logic            op_r;
  logic [31:0]     a_r, b_r;
  logic [RD_W-1:0] rd_r;

  logic            ctrl_mult_r, ctrl_div_r;
  logic            busy_r;
  logic [RD_W-1:0] busy_rd_r;
  logic            wb_valid_r;
  logic [31:0]     wb_data_r;
  logic [RD_W-1:0] wb_rd_r;
  logic            wb_exception_r;

  logic             req_ready_s, accept_s, stall_s;
  logic             cap_result_s, cap_timeout_s;
  logic             cnt_clear_s, cnt_enable_s, cnt_expired_s, first_wait_s;
  logic [CNT_W-1:0] cnt_s;

  assign cnt_clear_s  = (state_r != ST_WAIT);
  assign cnt_enable_s = (state_r == ST_WAIT);
  assign first_wait_s = (cnt_s == '0);

  md_timeout_counter #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_timeout (
    .clock   (clock),
    .reset   (reset),
    .clear   (cnt_clear_s),
    .enable  (cnt_enable_s),
    .count   (cnt_s),
    .expired (cnt_expired_s)
  );

  // Combinational handshake and pipeline stall
  always_comb begin
    req_ready_s = 1'b0;
    stall_s     = 1'b0;
    if (flush) begin
      req_ready_s = 1'b0;
      stall_s     = 1'b0;
    end else begin
      req_ready_s = (state_r == ST_IDLE) || ((state_r == ST_DONE) && bus.wb_ready);
      stall_s     = (state_r == ST_START) || (state_r == ST_WAIT) ||
                    ((state_r == ST_DONE) && !bus.wb_ready);
    end
  end

  assign accept_s = bus.req_valid && req_ready_s;

  // Next-state logic and completion qualifiers
  always_comb begin
    state_nxt_s   = state_r;
    cap_result_s  = 1'b0;
    cap_timeout_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_nxt_s = ST_START;
        else          state_nxt_s = ST_IDLE;
      end
      ST_START: begin
        if (flush) state_nxt_s = ST_IDLE;
        else       state_nxt_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (flush) begin
          state_nxt_s = ST_IDLE;
        end else if (rdy_honoured(md_resultRDY, first_wait_s)) begin
          state_nxt_s  = ST_DONE;
          cap_result_s = 1'b1;
        end else if (cnt_expired_s) begin
          state_nxt_s   = ST_DONE;
          cap_timeout_s = 1'b1;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_DONE: begin
        if (flush)                  state_nxt_s = ST_IDLE;
        else if (!bus.wb_ready)     state_nxt_s = ST_DONE;
        else if (accept_s)          state_nxt_s = ST_START;
        else                        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_r <= ST_IDLE;
    else        state_r <= state_nxt_s;
  end

  // Request capture; operands stay put until the next accept
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op_r <= 1'b0;
      a_r  <= 32'd0;
      b_r  <= 32'd0;
      rd_r <= '0;
    end else if (accept_s) begin
      op_r <= bus.req_op;
      a_r  <= bus.req_a;
      b_r  <= bus.req_b;
      rd_r <= bus.req_rd;
    end else begin
      op_r <= op_r;
      a_r  <= a_r;
      b_r  <= b_r;
      rd_r <= rd_r;
    end
  end

  // Start pulses and hazard outputs, registered from the next-state view
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ctrl_mult_r <= 1'b0;
      ctrl_div_r  <= 1'b0;
      busy_r      <= 1'b0;
      busy_rd_r   <= '0;
      wb_valid_r  <= 1'b0;
    end else begin
      ctrl_mult_r <= accept_s && (bus.req_op == OP_MULT);
      ctrl_div_r  <= accept_s && (bus.req_op == OP_DIV);
      busy_r      <= (state_nxt_s != ST_IDLE);
      wb_valid_r  <= (state_nxt_s == ST_DONE);
      if (state_nxt_s == ST_IDLE) busy_rd_r <= '0;
      else if (accept_s)          busy_rd_r <= bus.req_rd;
      else                        busy_rd_r <= rd_r;
    end
  end

  // Writeback payload; a timeout reports zero data with the exception flag
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wb_data_r      <= 32'd0;
      wb_rd_r        <= '0;
      wb_exception_r <= 1'b0;
    end else if (cap_result_s) begin
      wb_data_r      <= md_result;
      wb_rd_r        <= rd_r;
      wb_exception_r <= md_exception;
    end else if (cap_timeout_s) begin
      wb_data_r      <= 32'd0;
      wb_rd_r        <= rd_r;
      wb_exception_r <= 1'b1;
    end else begin
      wb_data_r      <= wb_data_r;
      wb_rd_r        <= wb_rd_r;
      wb_exception_r <= wb_exception_r;
    end
  end

  assign bus.req_ready    = req_ready_s;
  assign bus.wb_valid     = wb_valid_r;
  assign bus.wb_data      = wb_data_r;
  assign bus.wb_rd        = wb_rd_r;
  assign bus.wb_exception = wb_exception_r;

  assign stall        = stall_s;
  assign busy         = busy_r;
  assign busy_rd      = busy_rd_r;
  assign md_a         = a_r;
  assign md_b         = b_r;
  assign md_ctrl_mult = ctrl_mult_r;
  assign md_ctrl_div  = ctrl_div_r;

endmodule
